// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - fixed-point word parameters, dendrite state encoding and clamp helper
//
// Contents:
//   WORD_LENGTH   default signed word width
//   VMAX          largest positive value of a WORD_LENGTH word
//   dend_state_t  dendrite FSM state encoding
//   sat_clamp     clamps a signed value into [0, vmax]; callers sign-extend into 32 bits
package fp;

  localparam int WORD_LENGTH = 16;
  localparam int VMAX        = (1 << (WORD_LENGTH - 1)) - 1;

  typedef enum logic [1:0] {IDLE, INTEGRATE, EMIT, REFRACT} dend_state_t;

  function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v,
                                                   input logic signed [31:0] vmax);
    if (v < 0)
      return '0;
    else if (v > vmax)
      return vmax;
    else
      return v;
  endfunction

endpackage

// File: rtl/dendrite_adder_tree.sv
// rtl/dendrite_adder_tree.sv - combinational signed sum of NUM_IN packed operands
//
// Ports:
//   operands  NUM_IN x WIDTH packed signed values, operand 0 in the low bits
//   total     signed sum, OUT_W bits (OUT_W must cover WIDTH + clog2(NUM_IN))
module dendrite_adder_tree #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 16,
  parameter int OUT_W  = WIDTH + $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] operands,
  output logic signed [OUT_W-1:0] total
);

  always_comb begin
    total = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      total = total + OUT_W'($signed(operands[i*WIDTH +: WIDTH]));
    end
  end

endmodule

// File: rtl/dendrite_array.sv
// rtl/dendrite_array.sv - leaky saturating dendritic compartment with plateau event handshake
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   syn_current     NUM_SYN x WIDTH signed synaptic currents, sampled every cycle
//   thresh          unsigned firing threshold, 0 disables firing
//   vmem            registered membrane value in [0, 2^(WIDTH-1)-1]
//   plateau_valid   event pending toward the neuron
//   plateau_ready   neuron accepts the event
//   plateau_amp     membrane value that caused the event, stable while valid
//   sat_flag        sticky, set when the membrane clamps at its upper bound
//   refractory      high while in the refractory state
module dendrite_array
  import fp::*;
#(
  parameter int NUM_SYN       = 4,
  parameter int WIDTH         = WORD_LENGTH,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRAC_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SYN*WIDTH-1:0] syn_current,
  input  logic [WIDTH-1:0]         thresh,
  output logic [WIDTH-1:0]         vmem,
  output logic                     plateau_valid,
  input  logic                     plateau_ready,
  output logic [WIDTH-1:0]         plateau_amp,
  output logic                     sat_flag,
  output logic                     refractory
);

  // Two guard bits over the synapse sum keep vmem + sum - leak exact.
  localparam int SW     = WIDTH + $clog2(NUM_SYN) + 2;
  localparam int VMAX_I = (1 << (WIDTH - 1)) - 1;
  localparam int CW     = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((REFRAC_CYCLES > 0) ? REFRAC_CYCLES - 1 : 0);

  dend_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] vmem_d, amp_d, nv;
  logic valid_d, refr_d, sat_d;
  logic signed [SW-1:0] syn_sum, vmem_ext, leak, raw;
  logic over, any_in, fire, update;

  dendrite_adder_tree #(
    .NUM_IN(NUM_SYN),
    .WIDTH (WIDTH),
    .OUT_W (SW)
  ) u_adder_tree (
    .operands(syn_current),
    .total   (syn_sum)
  );

  // vmem is never negative, so zero-extension keeps it positive in SW bits.
  assign vmem_ext = SW'($signed({1'b0, vmem}));
  assign leak     = (LEAK_SHIFT == 0) ? '0 : (vmem_ext >>> LEAK_SHIFT);
  assign raw      = vmem_ext + syn_sum - leak;
  assign over     = raw > SW'(VMAX_I);
  assign nv       = WIDTH'(sat_clamp(32'(raw), VMAX_I));
  assign any_in   = |syn_current;
  assign fire     = (thresh != '0) && (nv >= thresh);

  // Membrane only follows nv in IDLE (when stimulated) and INTEGRATE.
  assign update   = ((state == IDLE) && any_in) || (state == INTEGRATE);

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (any_in)
          state_d = fire ? EMIT : INTEGRATE;
      end
      INTEGRATE: begin
        if (fire)
          state_d = EMIT;
        else if ((nv == '0) && !any_in)
          state_d = IDLE;
      end
      EMIT: begin
        if (plateau_valid && plateau_ready)
          state_d = (REFRAC_CYCLES == 0) ? IDLE : REFRACT;
      end
      REFRACT: begin
        if (cnt == '0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vmem_d  = vmem;
    amp_d   = plateau_amp;
    sat_d   = sat_flag;
    cnt_d   = cnt;
    valid_d = (state_d == EMIT);
    refr_d  = (state_d == REFRACT);

    if (update) begin
      vmem_d = fire ? '0 : nv;
      if (fire)
        amp_d = nv;
      if (over)
        sat_d = 1'b1;
    end else if ((state == EMIT) || (state == REFRACT)) begin
      vmem_d = '0;
    end

    if ((state == EMIT) && (state_d == REFRACT))
      cnt_d = CNT_LOAD;
    else if ((state == REFRACT) && (cnt != '0))
      cnt_d = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vmem          <= '0;
      plateau_amp   <= '0;
      plateau_valid <= 1'b0;
      sat_flag      <= 1'b0;
      refractory    <= 1'b0;
      cnt           <= '0;
    end else begin
      vmem          <= vmem_d;
      plateau_amp   <= amp_d;
      plateau_valid <= valid_d;
      sat_flag      <= sat_d;
      refractory    <= refr_d;
      cnt           <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dendrite_array.sv
// tb/tb_dendrite_array.sv - scoreboard bench for dendrite_array
module tb_dendrite_array;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk;
  logic           reset;
  logic [N*W-1:0] syn_current;
  logic [W-1:0]   thresh;
  logic [W-1:0]   vmem;
  logic           plateau_valid;
  logic           plateau_ready;
  logic [W-1:0]   plateau_amp;
  logic           sat_flag;
  logic           refractory;

  dendrite_array #(
    .NUM_SYN      (N),
    .WIDTH        (W),
    .LEAK_SHIFT   (4),
    .REFRAC_CYCLES(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .syn_current  (syn_current),
    .thresh       (thresh),
    .vmem         (vmem),
    .plateau_valid(plateau_valid),
    .plateau_ready(plateau_ready),
    .plateau_amp  (plateau_amp),
    .sat_flag     (sat_flag),
    .refractory   (refractory)
  );

  typedef struct {
    logic [W-1:0] vmem;
    logic         valid;
    logic         refr;
    logic         sat;
    logic [W-1:0] amp;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] evt_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int exp_amp  = 0;
  logic exp_sat = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expectation describes the outputs after the next rising edge.
  task automatic cyc(input int s0, input int s1, input int s2, input int s3,
                     input logic rdy, input logic rst,
                     input int e_vmem, input logic e_valid, input logic e_refr);
    exp_t e;
    @(negedge clk);
    syn_current   = {W'(s3), W'(s2), W'(s1), W'(s0)};
    plateau_ready = rdy;
    reset         = rst;
    e.vmem  = W'(e_vmem);
    e.valid = e_valid;
    e.refr  = e_refr;
    e.sat   = exp_sat;
    e.amp   = W'(exp_amp);
    exp_q.push_back(e);
  endtask

  // Monitor: a handshake seen just before an edge pops the event queue; every edge pops one cycle expectation.
  initial begin
    logic         hs;
    logic [W-1:0] amp_s;
    exp_t         e;
    forever begin
      @(negedge clk);
      #2;
      hs    = plateau_valid && plateau_ready && reset;
      amp_s = plateau_amp;
      @(posedge clk);
      #1;
      if (hs) begin
        if (evt_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          check("event_amp", int'(amp_s), int'(evt_q.pop_front()));
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("vmem",          int'(vmem),          int'(e.vmem));
        check("plateau_valid", int'(plateau_valid), int'(e.valid));
        check("refractory",    int'(refractory),    int'(e.refr));
        check("sat_flag",      int'(sat_flag),      int'(e.sat));
        check("plateau_amp",   int'(plateau_amp),   int'(e.amp));
      end
    end
  end

  initial begin
    reset         = 1'b0;
    syn_current   = '0;
    plateau_ready = 1'b0;
    thresh        = 16'd1000;

    // reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single pulse and leak decay, then cleared by a negative current
    cyc(100, 0, 0, 0, 0, 1, 100, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 94, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 89, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 84, 0, 0);
    cyc(-100, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // underflow clamps at zero
    cyc(50, 0, 0, 0, 0, 1, 50, 0, 0);
    cyc(0, 0, -200, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // mixed-sign inputs: 160 + 400 - 10
    cyc(160, 0, 0, 0, 0, 1, 160, 0, 0);
    cyc(300, -100, 250, -50, 0, 1, 550, 0, 0);
    cyc(-600, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // single-cycle crossing from IDLE, back-pressure, then refractory ignoring inputs
    exp_amp = 1100;
    evt_q.push_back(16'd1100);
    cyc(600, 500, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(400, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc(400, 0, 0, 0, 1, 1, 0, 0, 1);
    cyc(400, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(400, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(400, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // threshold boundary: 999 stays below, 999 + 63 - 62 == 1000 fires
    cyc(999, 0, 0, 0, 0, 1, 999, 0, 0);
    exp_amp = 1000;
    evt_q.push_back(16'd1000);
    cyc(63, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // reset while an event is pending drops it without a transfer
    exp_amp = 1200;
    cyc(1200, 0, 0, 0, 0, 1, 0, 1, 0);
    exp_amp = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // saturation with firing disabled; sat_flag stays set as the membrane leaks
    thresh  = 16'd0;
    exp_sat = 1'b1;
    cyc(16000, 16000, 16000, 16000, 0, 1, 32767, 0, 0);
    cyc(16000, 16000, 16000, 16000, 0, 1, 32767, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 30720, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 28800, 0, 0);

    @(negedge clk);
    @(negedge clk);
    check("pending_events", evt_q.size(), 0);
    check("pending_cycles", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
